saturn_bus_ctrl: RTL and testbench
==================================

Name: saturn_bus_ctrl

Overview:
- Sequences the nibble-serial Saturn system bus on behalf of the core.
- Arbitrates between two requesters: instruction fetch (decoder/PC path) and data access (ALU memory load/store).
- Keeps shadow copies of the bus-side PC and DP pointers, so it only issues address reloads on a discontinuity.
- Driven by the core's phase enables; issues at most one bus command per 4-phase cycle.

Parameters:
- ADDR_W, 20, address width in nibbles.
- LEN_W, 4, width of data length field; transfer is len+1 nibbles.

Ports:
- i_clk  in  1  system clock
- i_reset_n  in  1  asynchronous, active-low reset
- i_en_bus_send  in  1  phase-0 strobe; commands issue on this edge
- i_en_bus_recv  in  1  phase-1 strobe; read nibbles are sampled on this edge
- i_fetch_req  in  1  fetch wants the nibble at i_fetch_addr
- i_fetch_addr  in  ADDR_W  fetch address
- o_fetch_nibble  out  4  fetched nibble
- o_fetch_valid  out  1  one-clk pulse; o_fetch_nibble is valid
- i_data_req  in  1  data transfer request; held until o_data_done
- i_data_write  in  1  1 = write, 0 = read
- i_data_addr  in  ADDR_W  start address
- i_data_len  in  LEN_W  nibble count minus 1
- i_data_wnib  in  4  current write nibble
- o_data_wnext  out  1  one-clk pulse; i_data_wnib was consumed, present the next one
- o_data_rnib  out  4  read nibble
- o_data_rvalid  out  1  one-clk pulse per read nibble
- o_data_done  out  1  one-clk pulse after the last nibble
- o_busy  out  1  state != IDLE
- o_bus_cmd  out  3  0 NOP, 1 PC_READ, 2 DP_READ, 3 DP_WRITE, 4 LOAD_PC, 5 LOAD_DP
- o_bus_nibble_out  out  4  address or write nibble
- o_bus_strobe  out  1  one-clk command strobe
- i_bus_nibble_in  in  4  read data from the bus

Behaviour:
- Reset (async, i_reset_n=0):
  - All outputs are 0; o_bus_cmd = NOP.
  - State = IDLE.
  - Shadow pc_valid and dp_valid cleared; shadow pointers = 0; counters = 0.
  - Reset asserted mid-transfer aborts with no o_data_done.
- Register updates occur only on edges where i_en_bus_send or i_en_bus_recv = 1. Otherwise state holds and all pulses return to 0.
- States: IDLE, LOAD_ADDR, XFER.
- IDLE, on i_en_bus_send:
  - Grant: data wins over fetch when both are requested. Grant is latched with the address, direction and length.
  - Target pointer = DP for data, PC for fetch.
  - If the target is invalid or != address: go to LOAD_ADDR and issue LOAD_PC or LOAD_DP with address nibble 0 (LSN first).
  - Otherwise go to XFER and issue the first transfer command this same send edge.
  - With no request: stay in IDLE, cmd NOP, no strobe.
- LOAD_ADDR:
  - One address nibble per send edge; nibbles 1..4 in order, 5 strobes total.
  - After the 5th nibble: shadow = latched address, valid = 1, go to XFER.
  - The first transfer command issues on the next send edge.
- XFER:
  - Each send edge issues PC_READ, DP_READ or DP_WRITE.
  - Shadow pointer increments by 1 modulo 2^ADDR_W per command (0xFFFFF -> 0x00000).
  - Write: o_bus_nibble_out = i_data_wnib; o_data_wnext pulses on the same edge.
  - Read: the following recv edge latches i_bus_nibble_in into o_fetch_nibble / o_data_rnib and pulses the matching valid.
  - Fetch is a single nibble: after the recv edge, return to IDLE.
  - Data transfers count len+1 commands.
    - Read: o_data_done pulses on the recv edge of the last nibble, coincident with the last o_data_rvalid.
    - Write: o_data_done pulses on the send edge of the last command.
    - State returns to IDLE in both cases.
- Bus strobe timing: o_bus_strobe = 1 and o_bus_cmd valid for exactly the one clk following each issuing send edge; NOP and strobe 0 otherwise.
- No preemption: a granted sequence always completes with its latched address, even if request inputs change.
  - If i_fetch_addr changes during a sequence, the next grant sees the mismatch and reloads.
  - Dropping a request mid-sequence is illegal; the controller still completes the sequence.
- Per 4-phase cycle, at most one command issues. The next grant can occur on the send edge after a sequence ends.
- DP_WRITE and DP_READ never invalidate the PC shadow, and vice versa.

Test Plan:
- Reset release, fetch_req at 0x00000 -> strobes LOAD_PC with 0,0,0,0,0, then PC_READ; bus returns 0x2, so o_fetch_valid pulses with nibble 0x2 on the next recv edge.
- Follow-up fetch at 0x00001 -> single PC_READ, no LOAD_PC. Fetch at 0x00010 -> full LOAD_PC with nibbles 0,1,0,0,0.
- Fetch and data read (0x80100, len=4) requested on the same send edge -> LOAD_DP 0,0,1,0,8, five DP_READs, five rvalid pulses, done with the 5th. Fetch is then granted, with no PC reload.
- Data write at 0x00100, len=1, wnib 0xA then 0xB -> LOAD_DP, DP_WRITE 0xA, DP_WRITE 0xB, two wnext pulses, done on the 2nd send edge.
- Data read at 0xFFFFF, len=1 -> reads at 0xFFFFF and 0x00000. A subsequent read at 0x00001 issues no LOAD_DP.
- Reset asserted during the 3rd LOAD_DP nibble -> all outputs 0 immediately, with no done pulse. The next request reloads its address.

Source files
------------

// File: rtl/saturn_bus_ctrl.sv
// Nibble-serial Saturn bus sequencer: arbitrates fetch and data requests, keeps shadow
// PC/DP pointers and issues address reloads only when the requested address is discontinuous.
module saturn_bus_ctrl #(
    parameter int ADDR_W = 20,
    parameter int LEN_W  = 4
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_en_bus_send,
    input  logic              i_en_bus_recv,
    input  logic              i_fetch_req,
    input  logic [ADDR_W-1:0] i_fetch_addr,
    output logic [3:0]        o_fetch_nibble,
    output logic              o_fetch_valid,
    input  logic              i_data_req,
    input  logic              i_data_write,
    input  logic [ADDR_W-1:0] i_data_addr,
    input  logic [LEN_W-1:0]  i_data_len,
    input  logic [3:0]        i_data_wnib,
    output logic              o_data_wnext,
    output logic [3:0]        o_data_rnib,
    output logic              o_data_rvalid,
    output logic              o_data_done,
    output logic              o_busy,
    output logic [2:0]        o_bus_cmd,
    output logic [3:0]        o_bus_nibble_out,
    output logic              o_bus_strobe,
    input  logic [3:0]        i_bus_nibble_in
);

    localparam int NIBS = (ADDR_W + 3) / 4;
    localparam int NCW  = (NIBS > 1) ? $clog2(NIBS) : 1;

    localparam logic [2:0] CMD_NOP      = 3'd0;
    localparam logic [2:0] CMD_PC_READ  = 3'd1;
    localparam logic [2:0] CMD_DP_READ  = 3'd2;
    localparam logic [2:0] CMD_DP_WRITE = 3'd3;
    localparam logic [2:0] CMD_LOAD_PC  = 3'd4;
    localparam logic [2:0] CMD_LOAD_DP  = 3'd5;

    typedef enum logic [1:0] {IDLE, LOAD_ADDR, XFER} state_t;

    state_t             state_reg, state_next;
    logic               grant_data_reg, grant_data_next;
    logic               write_reg, write_next;
    logic [ADDR_W-1:0]  addr_reg, addr_next;
    logic [LEN_W-1:0]   len_reg, len_next;
    logic [LEN_W-1:0]   xfer_cnt_reg, xfer_cnt_next;
    logic [NCW-1:0]     nib_cnt_reg, nib_cnt_next;
    logic               rd_pend_reg, rd_pend_next;
    logic [ADDR_W-1:0]  pc_reg, pc_next;
    logic [ADDR_W-1:0]  dp_reg, dp_next;
    logic               pc_valid_reg, pc_valid_next;
    logic               dp_valid_reg, dp_valid_next;
    logic [3:0]         fetch_nibble_reg, fetch_nibble_next;
    logic               fetch_valid_reg, fetch_valid_next;
    logic               data_wnext_reg, data_wnext_next;
    logic [3:0]         data_rnib_reg, data_rnib_next;
    logic               data_rvalid_reg, data_rvalid_next;
    logic               data_done_reg, data_done_next;
    logic [2:0]         bus_cmd_reg, bus_cmd_next;
    logic [3:0]         bus_nibble_reg, bus_nibble_next;
    logic               bus_strobe_reg, bus_strobe_next;

    logic               sel_data, sel_write, issue;
    logic [LEN_W-1:0]   sel_len;
    logic [ADDR_W-1:0]  req_addr, tgt_ptr;
    logic               tgt_valid;

    // Data has priority, so the grant candidate follows i_data_req.
    assign req_addr  = i_data_req ? i_data_addr  : i_fetch_addr;
    assign tgt_ptr   = i_data_req ? dp_reg       : pc_reg;
    assign tgt_valid = i_data_req ? dp_valid_reg : pc_valid_reg;

    always_comb begin
        state_next        = state_reg;
        grant_data_next   = grant_data_reg;
        write_next        = write_reg;
        addr_next         = addr_reg;
        len_next          = len_reg;
        xfer_cnt_next     = xfer_cnt_reg;
        nib_cnt_next      = nib_cnt_reg;
        rd_pend_next      = rd_pend_reg;
        pc_next           = pc_reg;
        dp_next           = dp_reg;
        pc_valid_next     = pc_valid_reg;
        dp_valid_next     = dp_valid_reg;
        fetch_nibble_next = fetch_nibble_reg;
        data_rnib_next    = data_rnib_reg;
        fetch_valid_next  = 1'b0;
        data_wnext_next   = 1'b0;
        data_rvalid_next  = 1'b0;
        data_done_next    = 1'b0;
        bus_cmd_next      = CMD_NOP;
        bus_nibble_next   = 4'h0;
        bus_strobe_next   = 1'b0;
        issue             = 1'b0;

        // In IDLE a transfer can issue on the granting edge, before the grant is latched.
        if (state_reg == IDLE) begin
            sel_data  = i_data_req;
            sel_write = i_data_req & i_data_write;
            sel_len   = i_data_req ? i_data_len : '0;
        end else begin
            sel_data  = grant_data_reg;
            sel_write = write_reg;
            sel_len   = len_reg;
        end

        if (i_en_bus_send) begin
            unique case (state_reg)
                IDLE: begin
                    if (i_data_req || i_fetch_req) begin
                        grant_data_next = i_data_req;
                        write_next      = sel_write;
                        len_next        = sel_len;
                        addr_next       = req_addr;
                        if (!tgt_valid || tgt_ptr != req_addr) begin
                            state_next      = LOAD_ADDR;
                            bus_cmd_next    = i_data_req ? CMD_LOAD_DP : CMD_LOAD_PC;
                            bus_nibble_next = req_addr[3:0];
                            bus_strobe_next = 1'b1;
                            nib_cnt_next    = NCW'(1);
                        end else begin
                            issue = 1'b1;
                        end
                    end
                end
                LOAD_ADDR: begin
                    bus_cmd_next    = grant_data_reg ? CMD_LOAD_DP : CMD_LOAD_PC;
                    bus_nibble_next = 4'(addr_reg >> {nib_cnt_reg, 2'b00});
                    bus_strobe_next = 1'b1;
                    if (nib_cnt_reg == NCW'(NIBS - 1)) begin
                        nib_cnt_next = '0;
                        state_next   = XFER;
                        if (grant_data_reg) begin
                            dp_next       = addr_reg;
                            dp_valid_next = 1'b1;
                        end else begin
                            pc_next       = addr_reg;
                            pc_valid_next = 1'b1;
                        end
                    end else begin
                        nib_cnt_next = nib_cnt_reg + NCW'(1);
                    end
                end
                XFER: begin
                    issue = !rd_pend_reg;
                end
                default: ;
            endcase

            if (issue) begin
                bus_strobe_next = 1'b1;
                state_next      = XFER;
                if (!sel_data) begin
                    bus_cmd_next = CMD_PC_READ;
                    pc_next      = pc_reg + ADDR_W'(1);
                    rd_pend_next = 1'b1;
                end else begin
                    dp_next = dp_reg + ADDR_W'(1);
                    if (sel_write) begin
                        bus_cmd_next    = CMD_DP_WRITE;
                        bus_nibble_next = i_data_wnib;
                        data_wnext_next = 1'b1;
                        if (xfer_cnt_reg == sel_len) begin
                            data_done_next = 1'b1;
                            xfer_cnt_next  = '0;
                            state_next     = IDLE;
                        end else begin
                            xfer_cnt_next = xfer_cnt_reg + LEN_W'(1);
                        end
                    end else begin
                        bus_cmd_next = CMD_DP_READ;
                        rd_pend_next = 1'b1;
                    end
                end
            end
        end else if (i_en_bus_recv && state_reg == XFER && rd_pend_reg) begin
            rd_pend_next = 1'b0;
            if (grant_data_reg) begin
                data_rnib_next   = i_bus_nibble_in;
                data_rvalid_next = 1'b1;
            end else begin
                fetch_nibble_next = i_bus_nibble_in;
                fetch_valid_next  = 1'b1;
            end
            // Fetch carries len 0, so it always finishes on its first nibble.
            if (xfer_cnt_reg == len_reg) begin
                data_done_next = grant_data_reg;
                xfer_cnt_next  = '0;
                state_next     = IDLE;
            end else begin
                xfer_cnt_next = xfer_cnt_reg + LEN_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_reg        <= IDLE;
            grant_data_reg   <= 1'b0;
            write_reg        <= 1'b0;
            addr_reg         <= '0;
            len_reg          <= '0;
            xfer_cnt_reg     <= '0;
            nib_cnt_reg      <= '0;
            rd_pend_reg      <= 1'b0;
            pc_reg           <= '0;
            dp_reg           <= '0;
            pc_valid_reg     <= 1'b0;
            dp_valid_reg     <= 1'b0;
            fetch_nibble_reg <= 4'h0;
            fetch_valid_reg  <= 1'b0;
            data_wnext_reg   <= 1'b0;
            data_rnib_reg    <= 4'h0;
            data_rvalid_reg  <= 1'b0;
            data_done_reg    <= 1'b0;
            bus_cmd_reg      <= CMD_NOP;
            bus_nibble_reg   <= 4'h0;
            bus_strobe_reg   <= 1'b0;
        end else begin
            state_reg        <= state_next;
            grant_data_reg   <= grant_data_next;
            write_reg        <= write_next;
            addr_reg         <= addr_next;
            len_reg          <= len_next;
            xfer_cnt_reg     <= xfer_cnt_next;
            nib_cnt_reg      <= nib_cnt_next;
            rd_pend_reg      <= rd_pend_next;
            pc_reg           <= pc_next;
            dp_reg           <= dp_next;
            pc_valid_reg     <= pc_valid_next;
            dp_valid_reg     <= dp_valid_next;
            fetch_nibble_reg <= fetch_nibble_next;
            fetch_valid_reg  <= fetch_valid_next;
            data_wnext_reg   <= data_wnext_next;
            data_rnib_reg    <= data_rnib_next;
            data_rvalid_reg  <= data_rvalid_next;
            data_done_reg    <= data_done_next;
            bus_cmd_reg      <= bus_cmd_next;
            bus_nibble_reg   <= bus_nibble_next;
            bus_strobe_reg   <= bus_strobe_next;
        end
    end

    assign o_fetch_nibble   = fetch_nibble_reg;
    assign o_fetch_valid    = fetch_valid_reg;
    assign o_data_wnext     = data_wnext_reg;
    assign o_data_rnib      = data_rnib_reg;
    assign o_data_rvalid    = data_rvalid_reg;
    assign o_data_done      = data_done_reg;
    assign o_busy           = (state_reg != IDLE);
    assign o_bus_cmd        = bus_cmd_reg;
    assign o_bus_nibble_out = bus_nibble_reg;
    assign o_bus_strobe     = bus_strobe_reg;

endmodule

// File: tb/tb_saturn_bus_ctrl.sv
// Bench for saturn_bus_ctrl: a nibble-memory bus device plus a transaction-level model that
// predicts each request's command stream, read data and handshake pulses.
module tb_saturn_bus_ctrl;

    localparam logic [2:0] NOP = 3'd0, PCR = 3'd1, DPR = 3'd2, DPW = 3'd3, LPC = 3'd4, LDP = 3'd5;

    logic        clk = 1'b0;
    logic        i_reset_n, i_en_bus_send, i_en_bus_recv;
    logic        i_fetch_req, i_data_req, i_data_write;
    logic [19:0] i_fetch_addr, i_data_addr;
    logic [3:0]  i_data_len, i_data_wnib, i_bus_nibble_in;
    logic [3:0]  o_fetch_nibble, o_data_rnib, o_bus_nibble_out;
    logic        o_fetch_valid, o_data_wnext, o_data_rvalid, o_data_done, o_busy, o_bus_strobe;
    logic [2:0]  o_bus_cmd;

    always #5 clk = ~clk;

    saturn_bus_ctrl #(.ADDR_W(20), .LEN_W(4)) dut (
        .i_clk(clk), .i_reset_n(i_reset_n),
        .i_en_bus_send(i_en_bus_send), .i_en_bus_recv(i_en_bus_recv),
        .i_fetch_req(i_fetch_req), .i_fetch_addr(i_fetch_addr),
        .o_fetch_nibble(o_fetch_nibble), .o_fetch_valid(o_fetch_valid),
        .i_data_req(i_data_req), .i_data_write(i_data_write), .i_data_addr(i_data_addr),
        .i_data_len(i_data_len), .i_data_wnib(i_data_wnib), .o_data_wnext(o_data_wnext),
        .o_data_rnib(o_data_rnib), .o_data_rvalid(o_data_rvalid), .o_data_done(o_data_done),
        .o_busy(o_busy), .o_bus_cmd(o_bus_cmd), .o_bus_nibble_out(o_bus_nibble_out),
        .o_bus_strobe(o_bus_strobe), .i_bus_nibble_in(i_bus_nibble_in)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Bus device state and monitor records (written only by the monitor process)
    logic [3:0]  busmem [logic [19:0]];
    logic [19:0] bus_pc, bus_dp;
    int          ld_k;
    logic [6:0]  ev_q[$];
    logic [3:0]  rd_q[$];
    logic [3:0]  fn_q[$];
    int          done_total = 0, wnext_total = 0, done_bad_total = 0;

    // Reference model state (written only by the main process)
    logic [3:0]  refmem [logic [19:0]];
    logic [19:0] m_pc, m_dp;
    bit          m_pc_v, m_dp_v;
    bit          cur_w;
    logic [3:0]  wnib_tab [16];
    int          wbase = 0;

    assign i_data_wnib = wnib_tab[4'(wnext_total - wbase)];

    function automatic logic [3:0] init_nib(input logic [19:0] a);
        return a[3:0] ^ a[7:4] ^ a[11:8] ^ a[15:12] ^ a[19:16] ^ 4'h2;
    endfunction

    function automatic logic [3:0] bus_rd(input logic [19:0] a);
        if (busmem.exists(a)) return busmem[a];
        return init_nib(a);
    endfunction

    function automatic logic [3:0] ref_rd(input logic [19:0] a);
        if (refmem.exists(a)) return refmem[a];
        return init_nib(a);
    endfunction

    // Four-phase cycle stretched over 8 clocks: send on phase 0, recv on phase 2.
    initial begin
        int ph = 0;
        i_en_bus_send = 1'b0;
        i_en_bus_recv = 1'b0;
        forever begin
            @(negedge clk);
            i_en_bus_send = (ph == 0);
            i_en_bus_recv = (ph == 2);
            ph = (ph + 1) % 8;
        end
    end

    // Bus device and output monitor
    initial begin
        i_bus_nibble_in = 4'h0;
        bus_pc = '0;
        bus_dp = '0;
        ld_k = 0;
        forever begin
            @(negedge clk);
            if (!i_reset_n) begin
                ld_k = 0;
            end else begin
                if (o_bus_strobe) begin
                    ev_q.push_back({o_bus_cmd, (o_bus_cmd == PCR || o_bus_cmd == DPR) ? 4'h0 : o_bus_nibble_out});
                    case (o_bus_cmd)
                        PCR: begin i_bus_nibble_in = bus_rd(bus_pc); bus_pc = bus_pc + 20'd1; end
                        DPR: begin i_bus_nibble_in = bus_rd(bus_dp); bus_dp = bus_dp + 20'd1; end
                        DPW: begin busmem[bus_dp] = o_bus_nibble_out; bus_dp = bus_dp + 20'd1; end
                        LPC: begin bus_pc[ld_k*4 +: 4] = o_bus_nibble_out; ld_k = (ld_k == 4) ? 0 : ld_k + 1; end
                        LDP: begin bus_dp[ld_k*4 +: 4] = o_bus_nibble_out; ld_k = (ld_k == 4) ? 0 : ld_k + 1; end
                        default: ;
                    endcase
                end
                if (o_fetch_valid) fn_q.push_back(o_fetch_nibble);
                if (o_data_rvalid) rd_q.push_back(o_data_rnib);
                if (o_data_done) begin
                    done_total++;
                    if (cur_w ? !o_data_wnext : !o_data_rvalid) done_bad_total++;
                end
                if (o_data_wnext) wnext_total++;
            end
        end
    end

    task automatic run_txn(input string name, input bit f, input logic [19:0] fa, input bit d,
                           input bit w, input logic [19:0] da, input logic [3:0] len,
                           input logic [63:0] wpat);
        logic [6:0]  exp_ev[$];
        logic [3:0]  exp_rd[$];
        logic [3:0]  exp_fn[$];
        logic [19:0] a;
        int eb, rb, fb, db, wb, bb, cyc, nget, fd;
        bit pend_d, pend_f, ok;
        logic [6:0] gv, wv;

        @(negedge clk);
        #1;
        if (d) begin
            if (!m_dp_v || m_dp != da)
                for (int k = 0; k < 5; k++) exp_ev.push_back({LDP, da[4*k +: 4]});
            for (int i = 0; i <= int'(len); i++) begin
                a = da + 20'(i);
                if (w) begin
                    exp_ev.push_back({DPW, wpat[4*i +: 4]});
                    refmem[a] = wpat[4*i +: 4];
                end else begin
                    exp_ev.push_back({DPR, 4'h0});
                    exp_rd.push_back(ref_rd(a));
                end
            end
            m_dp = da + 20'(int'(len) + 1);
            m_dp_v = 1'b1;
        end
        if (f) begin
            if (!m_pc_v || m_pc != fa)
                for (int k = 0; k < 5; k++) exp_ev.push_back({LPC, fa[4*k +: 4]});
            exp_ev.push_back({PCR, 4'h0});
            exp_fn.push_back(ref_rd(fa));
            m_pc = fa + 20'd1;
            m_pc_v = 1'b1;
        end

        for (int i = 0; i < 16; i++) wnib_tab[i] = wpat[4*i +: 4];
        wbase = wnext_total;
        eb = ev_q.size(); rb = rd_q.size(); fb = fn_q.size();
        db = done_total; wb = wnext_total; bb = done_bad_total;
        cur_w = w;
        i_fetch_req = f;  i_fetch_addr = fa;
        i_data_req = d;   i_data_write = w; i_data_addr = da; i_data_len = len;

        pend_d = d; pend_f = f; cyc = 0;
        while ((pend_d || pend_f) && cyc < 800) begin
            @(negedge clk);
            #1;
            cyc++;
            if (pend_d && done_total > db) begin pend_d = 0; i_data_req = 1'b0; end
            if (pend_f && fn_q.size() > fb) begin pend_f = 0; i_fetch_req = 1'b0; end
        end
        i_data_req = 1'b0;
        i_fetch_req = 1'b0;
        repeat (16) @(negedge clk);
        #1;

        n_cmp++;
        if (pend_d || pend_f) begin
            n_err++;
            $display("FAIL %s timeout: data pending %0d fetch pending %0d, required both 0", name, pend_d, pend_f);
        end

        nget = ev_q.size() - eb;
        ok = (nget == exp_ev.size());
        fd = -1;
        for (int i = 0; i < nget && i < exp_ev.size(); i++)
            if (ev_q[eb+i] !== exp_ev[i] && fd < 0) begin fd = i; ok = 0; end
        gv = (fd >= 0) ? ev_q[eb+fd] : 7'h0;
        wv = (fd >= 0) ? exp_ev[fd] : 7'h0;
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s bus_seq: got %0d strobes, required %0d; first diff idx %0d got cmd/nib %h required %h",
                     name, nget, exp_ev.size(), fd, gv, wv);
        end

        nget = rd_q.size() - rb;
        ok = (nget == exp_rd.size());
        for (int i = 0; i < nget && i < exp_rd.size(); i++)
            if (rd_q[rb+i] !== exp_rd[i]) ok = 0;
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s read_data: got %0d nibbles (first %h), required %0d (first %h)", name, nget,
                     (nget > 0) ? rd_q[rb] : 4'h0, exp_rd.size(), (exp_rd.size() > 0) ? exp_rd[0] : 4'h0);
        end

        nget = fn_q.size() - fb;
        ok = (nget == exp_fn.size());
        for (int i = 0; i < nget && i < exp_fn.size(); i++)
            if (fn_q[fb+i] !== exp_fn[i]) ok = 0;
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s fetch_nibble: got %0d pulses (first %h), required %0d (first %h)", name, nget,
                     (nget > 0) ? fn_q[fb] : 4'h0, exp_fn.size(), (exp_fn.size() > 0) ? exp_fn[0] : 4'h0);
        end

        n_cmp++;
        if ((done_total - db) !== (d ? 1 : 0)) begin
            n_err++;
            $display("FAIL %s done_count: got %0d required %0d", name, done_total - db, d ? 1 : 0);
        end

        n_cmp++;
        if ((wnext_total - wb) !== ((d && w) ? int'(len) + 1 : 0)) begin
            n_err++;
            $display("FAIL %s wnext_count: got %0d required %0d", name, wnext_total - wb,
                     (d && w) ? int'(len) + 1 : 0);
        end

        if (d) begin
            n_cmp++;
            if ((done_bad_total - bb) !== 0) begin
                n_err++;
                $display("FAIL %s done_align: %0d done pulses not coincident with last rvalid/wnext, required 0",
                         name, done_bad_total - bb);
            end
        end

        n_cmp++;
        if (o_busy !== 1'b0) begin
            n_err++;
            $display("FAIL %s busy_after: got %b required 0", name, o_busy);
        end

        $display("txn %-12s fetch=%0d fa=%05h data=%0d wr=%0d da=%05h len=%0d strobes=%0d",
                 name, f, fa, d, w, da, len, ev_q.size() - eb);
    endtask

    task automatic test_reset();
        i_reset_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_cmp++;
        if ({o_fetch_nibble, o_fetch_valid, o_data_wnext, o_data_rnib, o_data_rvalid, o_data_done,
             o_busy, o_bus_cmd, o_bus_nibble_out, o_bus_strobe} !== 21'h0) begin
            n_err++;
            $display("FAIL reset_outputs: cmd %0d strobe %b busy %b, required all zero", o_bus_cmd, o_bus_strobe, o_busy);
        end
        @(negedge clk);
        i_reset_n = 1'b1;
        $display("txn reset       released");
    endtask

    task automatic test_idle();
        int eb;
        @(negedge clk);
        eb = ev_q.size();
        repeat (24) @(negedge clk);
        #1;
        n_cmp++;
        if ((ev_q.size() - eb) !== 0 || o_busy !== 1'b0) begin
            n_err++;
            $display("FAIL idle_quiet: got %0d strobes busy %b, required 0 strobes busy 0", ev_q.size() - eb, o_busy);
        end
        $display("txn idle        strobes=%0d", ev_q.size() - eb);
    endtask

    task automatic test_fetch();
        run_txn("fetch_0", 1, 20'h00000, 0, 0, 20'h0, 4'd0, 64'h0);
        run_txn("fetch_1", 1, 20'h00001, 0, 0, 20'h0, 4'd0, 64'h0);
        run_txn("fetch_10", 1, 20'h00010, 0, 0, 20'h0, 4'd0, 64'h0);
    endtask

    task automatic test_back_to_back();
        run_txn("combo_rd", 1, 20'h00011, 1, 0, 20'h80100, 4'd4, 64'h0);
    endtask

    task automatic test_write();
        run_txn("write_ab", 0, 20'h0, 1, 1, 20'h00100, 4'd1, 64'hBA);
        run_txn("read_back", 0, 20'h0, 1, 0, 20'h00100, 4'd1, 64'h0);
    endtask

    task automatic test_wrap();
        run_txn("wrap_rd", 0, 20'h0, 1, 0, 20'hFFFFF, 4'd1, 64'h0);
        run_txn("after_wrap", 0, 20'h0, 1, 0, 20'h00001, 4'd0, 64'h0);
    endtask

    task automatic test_reset_midload();
        int eb, db, cyc;
        @(negedge clk);
        #1;
        eb = ev_q.size();
        db = done_total;
        cur_w = 1'b0;
        i_data_req = 1'b1; i_data_write = 1'b0; i_data_addr = 20'h12345; i_data_len = 4'd2;
        cyc = 0;
        while ((ev_q.size() - eb) < 3 && cyc < 200) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        n_cmp++;
        if ({o_busy, o_bus_strobe, o_bus_cmd} !== {1'b1, 1'b1, LDP}) begin
            n_err++;
            $display("FAIL midload_state: busy %b strobe %b cmd %0d, required 1 1 %0d", o_busy, o_bus_strobe, o_bus_cmd, LDP);
        end
        i_reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({o_fetch_nibble, o_fetch_valid, o_data_wnext, o_data_rnib, o_data_rvalid, o_data_done,
             o_busy, o_bus_cmd, o_bus_nibble_out, o_bus_strobe} !== 21'h0) begin
            n_err++;
            $display("FAIL midload_reset: cmd %0d strobe %b busy %b, required all zero", o_bus_cmd, o_bus_strobe, o_busy);
        end
        repeat (20) @(negedge clk);
        i_data_req = 1'b0;
        i_reset_n = 1'b1;
        repeat (16) @(negedge clk);
        #1;
        n_cmp++;
        if ((done_total - db) !== 0 || (ev_q.size() - eb) !== 3) begin
            n_err++;
            $display("FAIL midload_abort: got %0d done %0d strobes, required 0 done 3 strobes",
                     done_total - db, ev_q.size() - eb);
        end
        $display("txn midload_rst strobes_before_reset=%0d", ev_q.size() - eb);
        m_pc = '0; m_dp = '0; m_pc_v = 0; m_dp_v = 0;
        run_txn("reload_rd", 0, 20'h0, 1, 0, 20'h12345, 4'd2, 64'h0);
    endtask

    task automatic test_random_traffic();
        logic [19:0] fa, da;
        int kind;
        for (int n = 0; n < 30; n++) begin
            kind = $urandom_range(0, 2);
            case ($urandom_range(0, 2))
                0: fa = m_pc;
                1: fa = 20'hFFFF8 + 20'($urandom_range(0, 15));
                default: fa = 20'($urandom);
            endcase
            case ($urandom_range(0, 2))
                0: da = m_dp;
                1: da = 20'hFFFF8 + 20'($urandom_range(0, 15));
                default: da = 20'($urandom);
            endcase
            run_txn($sformatf("rand_%0d", n), kind != 1, fa, kind != 0, 1'($urandom_range(0, 1)), da,
                    4'($urandom_range(0, 15)), {$urandom, $urandom});
        end
    endtask

    initial begin
        i_reset_n = 1'b0;
        i_fetch_req = 1'b0; i_fetch_addr = '0;
        i_data_req = 1'b0; i_data_write = 1'b0; i_data_addr = '0; i_data_len = '0;
        cur_w = 1'b0;
        for (int i = 0; i < 16; i++) wnib_tab[i] = 4'h0;
        m_pc = '0; m_dp = '0; m_pc_v = 0; m_dp_v = 0;

        test_reset();
        test_idle();
        test_fetch();
        test_back_to_back();
        test_write();
        test_wrap();
        test_reset_midload();
        test_random_traffic();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
